// File: rtl/sb_io_cell.sv
// sb_io_cell: bidirectional pad cell (WIDTH pins, one shared OE) with combinational, registered and DDR paths.
// Latency: combinational paths 0 cycles; registered data/OE 1 rising edge; registered input visible after its capturing edge.
// Backpressure: none; clk_en stalls every register and rst (synchronous, active-high) overrides clk_en.
// Ports: clk/rst/clk_en control; package_pin pad; output_enable shared drive enable;
//        d_out_0/d_out_1 output data (rise/fall in DDR); d_in_0/d_in_1 input data (rise/fall samples);
//        latch_input_value freezes d_in_0 in latch input modes.
module sb_io_cell #(
  parameter logic [5:0] PIN_TYPE = 6'b1010_01,
  parameter bit         PULLUP   = 1'b0,
  parameter int         WIDTH    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  inout  wire  [WIDTH-1:0] package_pin,
  input  logic             latch_input_value,
  input  logic             output_enable,
  input  logic [WIDTH-1:0] d_out_0,
  input  logic [WIDTH-1:0] d_out_1,
  output logic [WIDTH-1:0] d_in_0,
  output logic [WIDTH-1:0] d_in_1
);

  // The output codes split cleanly into two fields:
  //   [5:4] drive control: 00 never, 01 always, 10 OE combinational, 11 OE registered
  //   [3:2] data source:   10 combinational, 01 registered, 11 registered inverted, 00 DDR
  // Every undefined code has [5:4]=00 and therefore never drives.
  localparam logic [1:0] OUT_OE   = PIN_TYPE[5:4];
  localparam logic [1:0] OUT_DAT  = PIN_TYPE[3:2];
  localparam logic [1:0] IN_MODE  = PIN_TYPE[1:0];
  localparam bit         IN_LATCH = IN_MODE[1];   // 10 and 11 freeze d_in_0 on latch_input_value
  localparam bit         IN_REG   = ~IN_MODE[0];  // 00 and 10 present the registered samples

  logic [WIDTH-1:0] dout0_q, dout0_d;
  logic [WIDTH-1:0] dout1_q;
  logic             oe_q, oe_d;
  logic [WIDTH-1:0] din0_q, din0_d;
  logic [WIDTH-1:0] din1_q;
  logic [WIDTH-1:0] out_dat;
  logic             drv_en;

  // din0_q doubles as the hold element of the pure latch mode (11): it tracks the
  // pad on every enabled rising edge while the latch is open, and the output mux
  // below shows the live pad in that case, so it only matters once the latch closes.
  always_comb begin
    dout0_d = d_out_0;
    oe_d    = output_enable;
    din0_d  = din0_q;
    if (!(IN_LATCH && latch_input_value)) begin
      din0_d = package_pin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout0_q <= '0;
      oe_q    <= 1'b0;
      din0_q  <= '0;
    end else if (clk_en) begin
      dout0_q <= dout0_d;
      oe_q    <= oe_d;
      din0_q  <= din0_d;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      dout1_q <= '0;
      din1_q  <= '0;
    end else if (clk_en) begin
      dout1_q <= d_out_1;
      din1_q  <= package_pin;
    end
  end

  always_comb begin
    out_dat = '0;
    drv_en  = 1'b0;
    case (OUT_DAT)
      2'b10:   out_dat = d_out_0;
      2'b01:   out_dat = dout0_q;
      2'b11:   out_dat = ~dout0_q;
      default: out_dat = clk ? dout0_q : dout1_q;  // DDR: rise register while high, fall register while low
    endcase
    case (OUT_OE)
      2'b01:   drv_en = 1'b1;
      2'b10:   drv_en = output_enable;
      2'b11:   drv_en = oe_q;
      default: drv_en = 1'b0;
    endcase
  end

  assign package_pin = drv_en ? out_dat : {WIDTH{1'bz}};

  if (PULLUP) begin : g_pullup
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pullup u_pu (package_pin[i]);
    end
  end

  always_comb begin
    d_in_0 = din0_q;
    d_in_1 = '0;
    case (IN_MODE)
      2'b01:   d_in_0 = package_pin;
      2'b11:   d_in_0 = latch_input_value ? din0_q : package_pin;
      default: d_in_0 = din0_q;
    endcase
    if (IN_REG) begin
      d_in_1 = din1_q;
    end
  end

endmodule

// File: tb/tb_sb_io_cell.sv
// tb_sb_io_cell: scoreboard bench for sb_io_cell across five PIN_TYPE configurations.
// Latency: expectations are queued when stimulus is applied and popped when the output is sampled.
// Backpressure: n/a; shared clk/rst/clk_en/latch, per-instance data and OE.
module tb_sb_io_cell;

  logic clk = 1'b0;
  logic rst, clk_en, latch_iv;

  always #5 clk = ~clk;

  // A: 1010_01 x16, combinational both ways, bench can drive the pad
  logic        oe_a;
  logic [15:0] d0_a, d1_a, din0_a, din1_a, drv_a;
  logic        drv_a_en;
  wire  [15:0] pin_a;
  assign pin_a = drv_a_en ? drv_a : 16'hzzzz;

  // B: 0101_00, registered output, registered input
  logic oe_b, d0_b, d1_b, din0_b, din1_b;
  wire  pin_b;

  // C: 1101_01 with pullup, registered data and OE
  logic oe_c, d0_c, d1_c, din0_c, din1_c;
  wire  pin_c;

  // D: 0100_01, always-driven DDR
  logic oe_d, d0_d, d1_d, din0_d, din1_d;
  wire  pin_d;

  // E: 0000_11 with pullup, input latch, bench can drive the pad
  logic oe_e, d0_e, d1_e, din0_e, din1_e, drv_e, drv_e_en;
  wire  pin_e;
  assign pin_e = drv_e_en ? drv_e : 1'bz;

  sb_io_cell #(.PIN_TYPE(6'b1010_01), .PULLUP(1'b0), .WIDTH(16)) u_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .package_pin(pin_a), .latch_input_value(latch_iv),
    .output_enable(oe_a), .d_out_0(d0_a), .d_out_1(d1_a), .d_in_0(din0_a), .d_in_1(din1_a));
  sb_io_cell #(.PIN_TYPE(6'b0101_00), .PULLUP(1'b0), .WIDTH(1)) u_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .package_pin(pin_b), .latch_input_value(latch_iv),
    .output_enable(oe_b), .d_out_0(d0_b), .d_out_1(d1_b), .d_in_0(din0_b), .d_in_1(din1_b));
  sb_io_cell #(.PIN_TYPE(6'b1101_01), .PULLUP(1'b1), .WIDTH(1)) u_c (
    .clk(clk), .rst(rst), .clk_en(clk_en), .package_pin(pin_c), .latch_input_value(latch_iv),
    .output_enable(oe_c), .d_out_0(d0_c), .d_out_1(d1_c), .d_in_0(din0_c), .d_in_1(din1_c));
  sb_io_cell #(.PIN_TYPE(6'b0100_01), .PULLUP(1'b0), .WIDTH(1)) u_d (
    .clk(clk), .rst(rst), .clk_en(clk_en), .package_pin(pin_d), .latch_input_value(latch_iv),
    .output_enable(oe_d), .d_out_0(d0_d), .d_out_1(d1_d), .d_in_0(din0_d), .d_in_1(din1_d));
  sb_io_cell #(.PIN_TYPE(6'b0000_11), .PULLUP(1'b1), .WIDTH(1)) u_e (
    .clk(clk), .rst(rst), .clk_en(clk_en), .package_pin(pin_e), .latch_input_value(latch_iv),
    .output_enable(oe_e), .d_out_0(d0_e), .d_out_1(d1_e), .d_in_0(din0_e), .d_in_1(din1_e));

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] sb_q[$];

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input logic [15:0] v);
    sb_q.push_back(v);
  endtask

  // An empty queue yields X, which no sampled value matches.
  task automatic sb_pop_chk(input string tag, input logic [15:0] act);
    logic [15:0] e;
    e = 16'hxxxx;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    chk(tag, act, e);
  endtask

  task automatic tick_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; clk_en = 1'b1; latch_iv = 1'b0;
    oe_a = 1'b0; d0_a = '0; d1_a = '0; drv_a = '0; drv_a_en = 1'b0;
    oe_b = 1'b0; d0_b = 1'b0; d1_b = 1'b0;
    oe_c = 1'b0; d0_c = 1'b0; d1_c = 1'b0;
    oe_d = 1'b0; d0_d = 1'b1; d1_d = 1'b0;
    oe_e = 1'b0; d0_e = 1'b0; d1_e = 1'b0; drv_e = 1'b0; drv_e_en = 1'b0;

    // reset state (rising and falling registers both saw rst)
    tick_pos(); tick_pos();
    sb_push(16'h0); sb_push(16'h0); sb_push(16'h0);
    sb_pop_chk("rst_b_din0", 16'(din0_b));
    sb_pop_chk("rst_b_din1", 16'(din1_b));
    sb_pop_chk("rst_b_pad", 16'(pin_b));
    sb_push(16'h1);
    sb_pop_chk("rst_c_pad_z", 16'(pin_c));
    rst = 1'b0;

    // A: combinational drive with loopback, then bench-only drive
    oe_a = 1'b1; d0_a = 16'hA5C3; #1;
    sb_push(16'hA5C3); sb_push(16'hA5C3); sb_push(16'h0);
    sb_pop_chk("a_pad_drive", pin_a);
    sb_pop_chk("a_loopback", din0_a);
    sb_pop_chk("a_din1_zero", din1_a);
    oe_a = 1'b0; drv_a = 16'h1234; drv_a_en = 1'b1; #1;
    sb_push(16'h1234); sb_push(16'h1234);
    sb_pop_chk("a_pad_bench", pin_a);
    sb_pop_chk("a_din_bench", din0_a);
    drv_a_en = 1'b0;

    // B: registered output, rising/falling input capture, reset
    d0_b = 1'b1;
    sb_push(16'h1); sb_push(16'h0);
    tick_pos();
    sb_pop_chk("b_pad_after_edge", 16'(pin_b));
    sb_pop_chk("b_din0_not_yet", 16'(din0_b));
    sb_push(16'h1); sb_push(16'h0);
    tick_neg();
    sb_pop_chk("b_din1_fall", 16'(din1_b));
    sb_pop_chk("b_din0_still", 16'(din0_b));
    sb_push(16'h1);
    tick_pos();
    sb_pop_chk("b_din0_rise", 16'(din0_b));
    rst = 1'b1;
    sb_push(16'h0);
    tick_neg();
    sb_pop_chk("b_rst_din1", 16'(din1_b));
    sb_push(16'h0); sb_push(16'h0);
    tick_pos();
    sb_pop_chk("b_rst_din0", 16'(din0_b));
    sb_pop_chk("b_rst_pad", 16'(pin_b));
    rst = 1'b0; d0_b = 1'b0;

    // C: registered OE (pullup makes Z read as 1, driven data is 0)
    d0_c = 1'b0; oe_c = 1'b1; #1;
    sb_push(16'h1); sb_push(16'h1);
    sb_pop_chk("c_oe_pre_edge", 16'(pin_c));
    sb_pop_chk("c_din_pre_edge", 16'(din0_c));
    sb_push(16'h0); sb_push(16'h0);
    tick_pos();
    sb_pop_chk("c_oe_on", 16'(pin_c));
    sb_pop_chk("c_din_on", 16'(din0_c));
    clk_en = 1'b0; oe_c = 1'b0; d0_c = 1'b1;
    sb_push(16'h0);
    tick_pos();
    sb_pop_chk("c_frozen", 16'(pin_c));
    clk_en = 1'b1; oe_c = 1'b1;
    sb_push(16'h1);
    tick_pos();
    sb_pop_chk("c_data_1", 16'(pin_c));
    d0_c = 1'b0;
    sb_push(16'h0);
    tick_pos();
    sb_pop_chk("c_data_0", 16'(pin_c));
    oe_c = 1'b0; #1;
    sb_push(16'h0);
    sb_pop_chk("c_oe_off_pre_edge", 16'(pin_c));
    sb_push(16'h1);
    tick_pos();
    sb_pop_chk("c_oe_off", 16'(pin_c));
    oe_c = 1'b1;
    sb_push(16'h0);
    tick_pos();
    sb_pop_chk("c_oe_on_again", 16'(pin_c));
    rst = 1'b1;
    sb_push(16'h1);
    tick_pos();
    sb_pop_chk("c_rst_z", 16'(pin_c));
    rst = 1'b0;

    // D: DDR, high phase carries d_out_0, low phase carries d_out_1
    for (int i = 0; i < 3; i++) begin
      sb_push(16'h1);
      @(posedge clk); #2;
      sb_pop_chk("d_high", 16'(pin_d));
      sb_push(16'h0); sb_push(16'h0);
      @(negedge clk); #2;
      sb_pop_chk("d_low", 16'(pin_d));
      sb_pop_chk("d_low_loopback", 16'(din0_d));
    end
    d0_d = 1'b0; d1_d = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb_push(16'h0);
      @(posedge clk); #2;
      sb_pop_chk("d_high_swap", 16'(pin_d));
      sb_push(16'h1);
      @(negedge clk); #2;
      sb_pop_chk("d_low_swap", 16'(pin_d));
    end

    // E: input latch with pullup
    latch_iv = 1'b0; drv_e_en = 1'b0; #1;
    sb_push(16'h1);
    sb_pop_chk("e_pullup", 16'(din0_e));
    tick_pos();
    latch_iv = 1'b1; drv_e = 1'b0; drv_e_en = 1'b1; #1;
    sb_push(16'h0); sb_push(16'h1);
    sb_pop_chk("e_pad_bench0", 16'(pin_e));
    sb_pop_chk("e_latched", 16'(din0_e));
    sb_push(16'h1);
    tick_pos();
    sb_pop_chk("e_latched_edge", 16'(din0_e));
    latch_iv = 1'b0; #1;
    sb_push(16'h0); sb_push(16'h0);
    sb_pop_chk("e_open", 16'(din0_e));
    sb_pop_chk("e_din1_zero", 16'(din1_e));

    chk("sb_empty", 16'(sb_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
